// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake and control bus between the
// instruction source (master) and the ALU sequencer (slave).
//   INST/EXEC  : instruction word and level-sensitive execute request
//   FN         : ALU function code
//   Ain/Gin    : ALU staging/result register strobes
//   Gout       : G onto bus
//   Rin/Rout   : one-hot register-file write enable / bus drive
//   ExtEn/ImmEn: external data / immediate onto bus
//   IMM        : zero-padded immediate
//   Done       : one-cycle retire pulse
//   Tstep      : current timestep
interface alu_sequencer_if #(
  parameter int DATA_W = 10,
  parameter int NREG   = 4
);
  logic [DATA_W-1:0] INST;
  logic              EXEC;
  logic [3:0]        FN;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic [NREG-1:0]   Rin;
  logic [NREG-1:0]   Rout;
  logic              ExtEn;
  logic              ImmEn;
  logic [DATA_W-1:0] IMM;
  logic              Done;
  logic [1:0]        Tstep;

  modport master (
    output INST, EXEC,
    input  FN, Ain, Gin, Gout, Rin, Rout, ExtEn, ImmEn, IMM, Done, Tstep
  );

  modport slave (
    input  INST, EXEC,
    output FN, Ain, Gin, Gout, Rin, Rout, ExtEn, ImmEn, IMM, Done, Tstep
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control unit for the 10-bit processor.
// Captures an instruction on EXEC in T0, then walks T1..T3 driving ALU,
// register-file and bus-select controls; pulses Done on retire.
// Ports:
//   CLKb : clock, all state changes on the falling edge
//   Rstb : asynchronous active-low reset
//   bus  : alu_sequencer_if.slave (INST/EXEC in, control outputs out)
//
// state | meaning
// T0    | idle, waiting for EXEC; all outputs 0
// T1    | first step (ld/cp/reserved retire here)
// T2    | ALU operate step, G loaded
// T3    | G written back to Rx, retire
module alu_sequencer #(
  parameter int DATA_W = 10,
  parameter int NREG   = 4
) (
  input logic           CLKb,
  input logic           Rstb,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;
  typedef enum logic [2:0] {K_NOP, K_LD, K_CP, K_UNARY, K_BINARY, K_IMM} kind_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_ir;
  kind_t             w_kind;
  logic [3:0]        w_alu_fn;
  logic [NREG-1:0]   w_x_oh;
  logic [NREG-1:0]   w_y_oh;

  always_ff @(negedge CLKb or negedge Rstb) begin
    if (!Rstb) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == T0 && bus.EXEC) r_ir <= bus.INST;
    end
  end

  assign w_x_oh = NREG'(1) << r_ir[7:6];
  assign w_y_oh = NREG'(1) << r_ir[5:4];

  always_comb begin
    w_kind   = K_NOP;
    w_alu_fn = r_ir[3:0];
    case (r_ir[9:8])
      2'b00: begin
        case (r_ir[3:0])
          4'b0000:                   w_kind = K_LD;
          4'b0001:                   w_kind = K_CP;
          4'b0100, 4'b0101:          w_kind = K_UNARY;
          4'b0010, 4'b0011, 4'b0110, 4'b0111,
          4'b1000, 4'b1001, 4'b1010, 4'b1011:
                                     w_kind = K_BINARY;
          default:                   w_kind = K_NOP;
        endcase
      end
      2'b10: begin
        w_kind   = K_IMM;
        w_alu_fn = 4'b1100;
      end
      2'b11: begin
        w_kind   = K_IMM;
        w_alu_fn = 4'b1101;
      end
      default: w_kind = K_NOP;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    bus.FN    = 4'b0000;
    bus.Ain   = 1'b0;
    bus.Gin   = 1'b0;
    bus.Gout  = 1'b0;
    bus.Rin   = '0;
    bus.Rout  = '0;
    bus.ExtEn = 1'b0;
    bus.ImmEn = 1'b0;
    bus.Done  = 1'b0;
    case (r_state)
      T0: if (bus.EXEC) w_next = T1;
      T1: begin
        case (w_kind)
          K_LD: begin
            bus.ExtEn = 1'b1;
            bus.Rin   = w_x_oh;
            bus.Done  = 1'b1;
            w_next    = T0;
          end
          K_CP: begin
            bus.Rout = w_y_oh;
            bus.Rin  = w_x_oh;
            bus.Done = 1'b1;
            w_next   = T0;
          end
          K_UNARY: begin
            bus.Rout = w_y_oh;
            bus.Ain  = 1'b1;
            w_next   = T2;
          end
          K_BINARY, K_IMM: begin
            bus.Rout = w_x_oh;
            bus.Ain  = 1'b1;
            w_next   = T2;
          end
          default: begin
            bus.Done = 1'b1;
            w_next   = T0;
          end
        endcase
      end
      T2: begin
        bus.FN  = w_alu_fn;
        bus.Gin = 1'b1;
        // second operand source: Ry for binary, immediate for addi/subi
        if (w_kind == K_BINARY) bus.Rout  = w_y_oh;
        if (w_kind == K_IMM)    bus.ImmEn = 1'b1;
        w_next = T3;
      end
      T3: begin
        bus.Gout = 1'b1;
        bus.Rin  = w_x_oh;
        bus.Done = 1'b1;
        w_next   = T0;
      end
      default: w_next = T0;
    endcase
  end

  assign bus.Tstep = r_state;
  // held at 0 in T0 so every output is quiet while idle
  assign bus.IMM   = (r_state == T0) ? '0 : {{(DATA_W-6){1'b0}}, r_ir[5:0]};

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  typedef struct packed {
    logic [3:0] fn;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] rin;
    logic [3:0] rout;
    logic       exten;
    logic       immen;
    logic       done;
    logic [9:0] imm;
    logic [1:0] tstep;
  } obs_t;

  typedef struct {
    string      name;
    logic [9:0] inst;
    int         n;
    obs_t       s1;
    obs_t       s2;
    obs_t       s3;
  } vec_t;

  logic CLKb;
  logic Rstb;
  int   n_checks;
  int   n_pass;
  obs_t sbq[$];
  vec_t vecs[$];

  alu_sequencer_if bus();

  alu_sequencer dut (
    .CLKb (CLKb),
    .Rstb (Rstb),
    .bus  (bus)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  function automatic obs_t mk(logic [3:0] fn, logic ain, logic gin, logic gout,
                              logic [3:0] rin, logic [3:0] rout, logic ext,
                              logic immen, logic done);
    obs_t o;
    o = '0;
    o.fn = fn; o.ain = ain; o.gin = gin; o.gout = gout;
    o.rin = rin; o.rout = rout; o.exten = ext; o.immen = immen; o.done = done;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.fn = bus.FN; o.ain = bus.Ain; o.gin = bus.Gin; o.gout = bus.Gout;
    o.rin = bus.Rin; o.rout = bus.Rout; o.exten = bus.ExtEn;
    o.immen = bus.ImmEn; o.done = bus.Done; o.imm = bus.IMM;
    o.tstep = bus.Tstep;
    return o;
  endfunction

  task automatic chk(string name, obs_t got, obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic chk_int(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  // expected step records; IMM is visible in every non-idle step
  task automatic push_steps(vec_t v);
    obs_t s[3];
    s[0] = v.s1; s[1] = v.s2; s[2] = v.s3;
    for (int i = 0; i < v.n; i++) begin
      s[i].tstep = 2'(i + 1);
      s[i].imm   = {4'b0, v.inst[5:0]};
      sbq.push_back(s[i]);
    end
  endtask

  // monitor: sample mid-cycle (rising edge); idle must be all zero
  always @(posedge CLKb) begin
    obs_t g;
    g = sample();
    if (g.tstep == 2'd0) chk("idle_zero", g, '0);
    else if (sbq.size() == 0) chk("unexpected_step", g, '0);
    else chk("step", g, sbq.pop_front());
  end

  task automatic wait_idle(string name);
    for (int i = 0; i < 12; i++) begin
      @(posedge CLKb);
      if (bus.Tstep == 2'd0) return;
    end
    chk_int({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_step(string name, logic [1:0] t);
    for (int i = 0; i < 12; i++) begin
      @(posedge CLKb);
      if (bus.Tstep == t) return;
    end
    chk_int({name, "_timeout"}, 1, 0);
  endtask

  task automatic run_vec(vec_t v);
    @(posedge CLKb);
    bus.INST = v.inst;
    bus.EXEC = 1'b1;
    push_steps(v);
    @(negedge CLKb);
    @(posedge CLKb);
    bus.EXEC = 1'b0;
    bus.INST = 10'($urandom);
    wait_idle(v.name);
  endtask

  function automatic vec_t vv(string name, logic [9:0] inst, int n,
                              obs_t s1, obs_t s2, obs_t s3);
    vec_t v;
    v.name = name; v.inst = inst; v.n = n; v.s1 = s1; v.s2 = s2; v.s3 = s3;
    return v;
  endfunction

  initial begin
    vec_t add_v, subi_v, inv_v;
    n_checks = 0;
    n_pass   = 0;

    //               fn       ain gin gout rin      rout     ext imm done
    vecs.push_back(vv("ld_r2", 10'h080, 1,
      mk(4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 1, 0, 1), '0, '0));
    vecs.push_back(vv("cp_r3_r1", 10'h0D1, 1,
      mk(4'b0000, 0, 0, 0, 4'b1000, 4'b0010, 0, 0, 1), '0, '0));
    vecs.push_back(vv("add_r1_r2", 10'h062, 3,
      mk(4'b0000, 1, 0, 0, 4'b0000, 4'b0010, 0, 0, 0),
      mk(4'b0010, 0, 1, 0, 4'b0000, 4'b0100, 0, 0, 0),
      mk(4'b0000, 0, 0, 1, 4'b0010, 4'b0000, 0, 0, 1)));
    vecs.push_back(vv("and_r2_r3", 10'h0B6, 3,
      mk(4'b0000, 1, 0, 0, 4'b0000, 4'b0100, 0, 0, 0),
      mk(4'b0110, 0, 1, 0, 4'b0000, 4'b1000, 0, 0, 0),
      mk(4'b0000, 0, 0, 1, 4'b0100, 4'b0000, 0, 0, 1)));
    vecs.push_back(vv("add_r1_r1", 10'h052, 3,
      mk(4'b0000, 1, 0, 0, 4'b0000, 4'b0010, 0, 0, 0),
      mk(4'b0010, 0, 1, 0, 4'b0000, 4'b0010, 0, 0, 0),
      mk(4'b0000, 0, 0, 1, 4'b0010, 4'b0000, 0, 0, 1)));
    vecs.push_back(vv("flp_r2_r0", 10'h085, 3,
      mk(4'b0000, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0),
      mk(4'b0101, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0),
      mk(4'b0000, 0, 0, 1, 4'b0100, 4'b0000, 0, 0, 1)));
    vecs.push_back(vv("addi_r3", 10'h2EA, 3,
      mk(4'b0000, 1, 0, 0, 4'b0000, 4'b1000, 0, 0, 0),
      mk(4'b1100, 0, 1, 0, 4'b0000, 4'b0000, 0, 1, 0),
      mk(4'b0000, 0, 0, 1, 4'b1000, 4'b0000, 0, 0, 1)));
    vecs.push_back(vv("reserved", 10'h100, 1,
      mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1), '0, '0));
    vecs.push_back(vv("illegal_f", 10'h00F, 1,
      mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1), '0, '0));
    vecs.push_back(vv("illegal_c", 10'h0CC, 1,
      mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1), '0, '0));
    add_v  = vecs[2];
    subi_v = vv("subi_r0", 10'h305, 3,
      mk(4'b0000, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0),
      mk(4'b1101, 0, 1, 0, 4'b0000, 4'b0000, 0, 1, 0),
      mk(4'b0000, 0, 0, 1, 4'b0001, 4'b0000, 0, 0, 1));
    inv_v  = vv("inv_r0_r1", 10'h014, 3,
      mk(4'b0000, 1, 0, 0, 4'b0000, 4'b0010, 0, 0, 0),
      mk(4'b0100, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0),
      mk(4'b0000, 0, 0, 1, 4'b0001, 4'b0000, 0, 0, 1));

    // power-on reset
    Rstb     = 1'b0;
    bus.EXEC = 1'b0;
    bus.INST = 10'h000;
    #1;
    chk("reset_state", sample(), '0);
    repeat (2) @(posedge CLKb);
    #2 Rstb = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset in T2 of an add: outputs drop at once, instruction abandoned
    @(posedge CLKb);
    bus.INST = add_v.inst;
    bus.EXEC = 1'b1;
    push_steps(add_v);
    @(negedge CLKb);
    @(posedge CLKb);
    bus.EXEC = 1'b0;
    wait_step("rst_wait_t2", 2'd2);
    #2 Rstb = 1'b0;
    #1 chk("reset_mid_add", sample(), '0);
    sbq.delete();
    repeat (2) @(posedge CLKb);
    #2 Rstb = 1'b1;
    repeat (3) @(posedge CLKb);
    chk_int("idle_after_reset", int'(bus.Tstep), 0);

    // back-to-back with EXEC held, INST toggled mid-instruction
    @(posedge CLKb);
    bus.INST = subi_v.inst;
    bus.EXEC = 1'b1;
    push_steps(subi_v);
    @(negedge CLKb);
    @(posedge CLKb);
    bus.INST = 10'h0A2;
    wait_step("b2b_wait_t3", 2'd3);
    bus.INST = inv_v.inst;
    push_steps(inv_v);
    @(posedge CLKb);
    chk_int("b2b_gap_t0", int'(bus.Tstep), 0);
    @(posedge CLKb);
    chk_int("b2b_second_t1", int'(bus.Tstep), 1);
    bus.EXEC = 1'b0;
    bus.INST = 10'h3FF;
    wait_idle("b2b_inv");

    // idle with EXEC low must not start anything
    bus.INST = 10'h062;
    repeat (3) @(posedge CLKb);
    chk_int("no_exec_idle", int'(bus.Tstep), 0);
    chk_int("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit that sits directly upstream of the ALU and register file in the 10-bit processor.
- Captures one 10-bit instruction per execute request and decodes it.
- Steps through timesteps T0–T3, driving the ALU function code, the A/G register strobes, the register-file in/out enables and the bus source selects.
- Pulses Done when the instruction retires.

Parameters:
- DATA_W, 10, instruction and data bus width.
- NREG, 4, number of general registers; Rin/Rout are one-hot NREG wide.

Ports:
- CLKb  input  1  system clock; all state updates on its negative edge.
- Rstb  input  1  asynchronous active-low reset.
- INST  input  DATA_W  instruction word; sampled only when leaving T0.
- EXEC  input  1  execute request; level-sensitive, sampled in T0.
- FN  output  4  ALU function code (LOAD 0000 … SUBI 1101).
- Ain  output  1  load ALU staging register A.
- Gin  output  1  load ALU result register G.
- Gout  output  1  drive G onto the bus.
- Rin  output  NREG  one-hot register-file write enable.
- Rout  output  NREG  one-hot register-file bus drive.
- ExtEn  output  1  drive external slide-switch data onto the bus.
- ImmEn  output  1  drive IMM onto the bus.
- IMM  output  DATA_W  zero-padded immediate {4'b0, IR[5:0]}.
- Done  output  1  one-cycle retire pulse.
- Tstep  output  2  current timestep, for display.

Behaviour:
- One clock (CLKb, negedge); reset is asynchronous and active-low (Rstb).
- While Rstb is low, immediately: state=T0, IR=0, all outputs 0.
  - Reset mid-instruction abandons the instruction with no partial write after assertion.
- All outputs are Moore-decoded from the registered state and IR (no combinational path from INST or EXEC). Every output is 0 in T0.
- T0:
  - If EXEC=1 at a negedge: IR<=INST, go to T1.
  - Otherwise stay in T0.
- Decode:
  - IR[9:8]=00: register op; X=IR[7:6], Y=IR[5:4], FN=IR[3:0].
  - IR[9:8]=10: addi, FN=1100, X=IR[7:6].
  - IR[9:8]=11: subi, FN=1101, X=IR[7:6].
  - IR[9:8]=01: reserved.
- Sequences (Done is asserted in the last step listed; the next state after that step is T0):
  - ld (FN 0000): T1: ExtEn, Rin[X], Done.
  - cp (FN 0001): T1: Rout[Y], Rin[X], Done.
  - inv/flp (0100/0101):
    - T1: Rout[Y], Ain.
    - T2: FN, Gin.
    - T3: Gout, Rin[X], Done.
  - Binary ops (0010, 0011, 0110–1011):
    - T1: Rout[X], Ain.
    - T2: Rout[Y], FN, Gin.
    - T3: Gout, Rin[X], Done.
  - addi/subi:
    - T1: Rout[X], Ain.
    - T2: ImmEn, FN, Gin.
    - T3: Gout, Rin[X], Done.
  - Register-op FN 1100–1111 and class 01: T1: Done only; no Rin, Ain or Gin.
- FN output is 0000 in every step except the Gin step.
- Latency: ld/cp/reserved take 2 cycles T0→T0; all others take 4.
- Bus exclusivity: at most one of Rout/ExtEn/ImmEn/Gout is active in any step; at most one Rin bit is set.
- EXEC held high: a new instruction is accepted in the T0 directly after Done, so back-to-back execution is permitted. EXEC is ignored outside T0.
- INST changing during T1–T3 has no effect; IR holds.
- X==Y (e.g. add R1,R1): the sequence is unchanged; Rout and Rin target the same register in different steps.

Test Plan:
- Reset: Rstb=0 while in T2 of an add → outputs all 0 immediately. Release, no EXEC → remains in T0 with Tstep=00.
- ld R2:
  - INST=0x080, EXEC pulse.
  - T1: ExtEn=1, Rin=0100, Done=1.
  - Next negedge: Tstep=00.
- add R1,R2:
  - INST=0x062.
  - T1: Rout=0010, Ain=1.
  - T2: Rout=0100, FN=0010, Gin=1.
  - T3: Gout=1, Rin=0010, Done=1.
- addi R3,6'b101010:
  - INST=0x2EA.
  - T1: Rout=1000, Ain=1.
  - T2: ImmEn=1, IMM=0x02A, FN=1100, Gin=1.
  - T3: Gout=1, Rin=1000, Done=1.
- Back-to-back with EXEC held:
  - Instructions: subi R0,5 (INST=0x305), then inv R0,R1 (INST=0x014).
  - Second instruction is captured the cycle after the first Done.
  - inv R0,R1: T1 Rout=0010, Ain=1; T3 Rin=0001.
  - INST toggled mid-instruction has no effect.
- Reserved and illegal:
  - INST=0x100: T1 Done=1 only, Rin=0.
  - INST=0x00F: same result (Done only, Rin=0).
